mac_stream_driver: RTL

- Host-side initiator for the 4x4-bit MAC accelerator. It buffers packed operand pairs, clears the MAC, and streams one pair per cycle into it.
- After the MAC pipeline latency it captures the 8-bit accumulated result and presents it on a valid/ready result port.
- Sits between the chip-level byte interface and the MAC core's a/b/C pins.

---
 rtl/mac_stream_driver.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mac_stream_driver.sv
// mac_stream_driver: host-side initiator for a 4x4-bit MAC accelerator.
// Buffers packed operand pairs in a FIFO, clears the MAC, streams one pair per
// cycle into it, waits out the MAC latency and presents the captured result
// on a valid/ready port.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   in_data_i/valid/ready  operand pair input, a=[3:0], b=[7:4]
//   start_i                single-cycle pulse launching a run (IDLE only)
//   mac_a_o/mac_b_o        operands to the MAC
//   mac_en_o/mac_clr_o     accumulate strobe / accumulator clear
//   mac_c_i                MAC accumulated result
//   res_data/valid/ready   captured result handshake
//   busy_o                 high outside IDLE
//   count_o                FIFO occupancy
module mac_stream_driver #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned LAT   = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [7:0]                 in_data_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic                       start_i,
   output logic [3:0]                 mac_a_o,
   output logic [3:0]                 mac_b_o,
   output logic                       mac_en_o,
   output logic                       mac_clr_o,
   input  logic [7:0]                 mac_c_i,
   output logic [7:0]                 res_data_o,
   output logic                       res_valid_o,
   input  logic                       res_ready_i,
   output logic                       busy_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned LW = 2;
   localparam logic [CW-1:0] CntMax  = CW'(DEPTH);
   localparam logic [LW-1:0] LatLast = LW'(LAT - 1);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StClear = 3'd1;
   localparam logic [2:0] StIssue = 3'd2;
   localparam logic [2:0] StDrain = 3'd3;
   localparam logic [2:0] StHold  = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [3:0]    mac_a_q, mac_a_d;
   logic [3:0]    mac_b_q, mac_b_d;
   logic          mac_en_q, mac_en_d;
   logic          mac_clr_q, mac_clr_d;
   logic [7:0]    res_data_q, res_data_d;
   logic          res_valid_q, res_valid_d;
   logic [7:0]    mem_q [DEPTH];

   logic wr_en;
   logic pop;

   assign in_ready_o = (state_q == StIdle) && (count_q < CntMax);
   assign wr_en      = in_valid_i && in_ready_o;
   assign busy_o     = (state_q != StIdle);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      lat_d       = lat_q;
      mac_a_d     = 4'd0;
      mac_b_d     = 4'd0;
      mac_en_d    = 1'b0;
      mac_clr_d   = 1'b0;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      pop         = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A write in the same cycle as start joins the run.
            if (start_i && ((count_q != '0) || wr_en)) begin
               state_d   = StClear;
               mac_clr_d = 1'b1;
            end
         end
         StClear: begin
            // First pop is issued here so mac_en lines up with ISSUE.
            state_d = StIssue;
            pop     = 1'b1;
         end
         StIssue: begin
            if (count_q != '0) begin
               pop = 1'b1;
            end else begin
               state_d = StDrain;
               lat_d   = '0;
            end
         end
         StDrain: begin
            if (lat_q == LatLast) begin
               res_data_d  = mac_c_i;
               res_valid_d = 1'b1;
               state_d     = StHold;
            end else begin
               lat_d = lat_q + LW'(1);
            end
         end
         StHold: begin
            if (res_ready_i) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (pop) begin
         mac_a_d  = mem_q[rd_ptr_q][3:0];
         mac_b_d  = mem_q[rd_ptr_q][7:4];
         mac_en_d = 1'b1;
         rd_ptr_d = rd_ptr_q + PW'(1);
         count_d  = count_q - CW'(1);
      end

      // Writes only in IDLE and pops only in CLEAR/ISSUE, so never both.
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         count_d  = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         lat_q       <= '0;
         mac_a_q     <= 4'd0;
         mac_b_q     <= 4'd0;
         mac_en_q    <= 1'b0;
         mac_clr_q   <= 1'b0;
         res_data_q  <= 8'd0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         lat_q       <= lat_d;
         mac_a_q     <= mac_a_d;
         mac_b_q     <= mac_b_d;
         mac_en_q    <= mac_en_d;
         mac_clr_q   <= mac_clr_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
      end
   end

   // Storage needs no reset: count and pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= in_data_i;
      end
   end

   assign mac_a_o     = mac_a_q;
   assign mac_b_o     = mac_b_q;
   assign mac_en_o    = mac_en_q;
   assign mac_clr_o   = mac_clr_q;
   assign res_data_o  = res_data_q;
   assign res_valid_o = res_valid_q;
   assign count_o     = count_q;

endmodule
